// File: rtl/axi_channel_arbiter.sv
// Four-input round-robin packet arbiter merging s00/s01/s20/s21 write streams onto one registered output.
// Optional macro ARB_CHANNEL_ID_EN adds m00_axi_rid carrying the owner index of each output beat.
module axi_channel_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BEATS  = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s00_axi_wdata,
    input  logic                  s00_axi_wvalid,
    input  logic                  s00_axi_wlast,
    output logic                  s00_axi_wready,
    input  logic [DATA_WIDTH-1:0] s01_axi_wdata,
    input  logic                  s01_axi_wvalid,
    input  logic                  s01_axi_wlast,
    output logic                  s01_axi_wready,
    input  logic [DATA_WIDTH-1:0] s20_axi_wdata,
    input  logic                  s20_axi_wvalid,
    input  logic                  s20_axi_wlast,
    output logic                  s20_axi_wready,
    input  logic [DATA_WIDTH-1:0] s21_axi_wdata,
    input  logic                  s21_axi_wvalid,
    input  logic                  s21_axi_wlast,
    output logic                  s21_axi_wready,
    output logic [DATA_WIDTH-1:0] m00_axi_rdata,
    output logic                  m00_axi_rvalid,
    output logic                  m00_axi_rlast,
    input  logic                  m00_axi_rready,
`ifdef ARB_CHANNEL_ID_EN
    output logic [1:0]            m00_axi_rid,
`endif
    output logic [3:0]            grant
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [1:0]            r_owner;
    logic [1:0]            r_ptr;
    logic [15:0]           r_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_rlast;
`ifdef ARB_CHANNEL_ID_EN
    logic [1:0]            r_rid;
`endif

    logic [3:0]            w_valid;
    logic [3:0]            w_last;
    logic [3:0]            w_rot;
    logic [3:0]            w_wready;
    logic [1:0]            w_offset;
    logic [1:0]            w_pick;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_ownerData;
    logic                  w_ownerValid;
    logic                  w_ownerLast;
    logic                  w_outReady;
    logic                  w_accept;
    logic                  w_countMax;
    logic                  w_release;

    assign w_valid = {s21_axi_wvalid, s20_axi_wvalid, s01_axi_wvalid, s00_axi_wvalid};
    assign w_last  = {s21_axi_wlast, s20_axi_wlast, s01_axi_wlast, s00_axi_wlast};

    // Rotate requests so bit 0 is the channel at the pointer; lowest set bit wins.
    always_comb begin
        w_rot = w_valid;
        case (r_ptr)
            2'd0:    w_rot = w_valid;
            2'd1:    w_rot = {w_valid[0], w_valid[3:1]};
            2'd2:    w_rot = {w_valid[1:0], w_valid[3:2]};
            default: w_rot = {w_valid[2:0], w_valid[3]};
        endcase
    end

    always_comb begin
        w_offset = 2'd0;
        if (w_rot[0])      w_offset = 2'd0;
        else if (w_rot[1]) w_offset = 2'd1;
        else if (w_rot[2]) w_offset = 2'd2;
        else if (w_rot[3]) w_offset = 2'd3;
    end

    assign w_found = |w_rot;
    assign w_pick  = r_ptr + w_offset;

    always_comb begin
        w_ownerData = s00_axi_wdata;
        case (r_owner)
            2'd0:    w_ownerData = s00_axi_wdata;
            2'd1:    w_ownerData = s01_axi_wdata;
            2'd2:    w_ownerData = s20_axi_wdata;
            default: w_ownerData = s21_axi_wdata;
        endcase
    end

    assign w_ownerValid = w_valid[r_owner];
    assign w_ownerLast  = w_last[r_owner];
    assign w_outReady   = !r_rvalid || m00_axi_rready;
    assign w_accept     = (r_state == BURST) && w_ownerValid && w_outReady;
    // Beat number MAX_BEATS ends the grant even without wlast.
    assign w_countMax   = (r_count == 16'(MAX_BEATS - 1));
    assign w_release    = w_ownerLast || w_countMax;

    always_comb begin
        w_wready = 4'b0000;
        if (r_state == BURST) begin
            w_wready[r_owner] = w_outReady;
        end
    end

    assign s00_axi_wready = w_wready[0];
    assign s01_axi_wready = w_wready[1];
    assign s20_axi_wready = w_wready[2];
    assign s21_axi_wready = w_wready[3];

    always_comb begin
        grant = 4'b0000;
        if (r_state == BURST) begin
            grant = 4'b0001 << r_owner;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_found) w_nextState = BURST;
            BURST:   if (w_accept && w_release) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_count <= 16'd0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_owner <= w_pick;
                r_count <= 16'd0;
            end
            if (w_accept) begin
                if (w_release) begin
                    r_count <= 16'd0;
                    r_ptr   <= r_owner + 2'd1;
                end else begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    // Single-entry output register; holds its beat while downstream stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
`ifdef ARB_CHANNEL_ID_EN
            r_rid    <= 2'd0;
`endif
        end else if (w_accept) begin
            r_rdata  <= w_ownerData;
            r_rvalid <= 1'b1;
            r_rlast  <= w_release;
`ifdef ARB_CHANNEL_ID_EN
            r_rid    <= r_owner;
`endif
        end else if (m00_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign m00_axi_rdata  = r_rdata;
    assign m00_axi_rvalid = r_rvalid;
    assign m00_axi_rlast  = r_rlast;
`ifdef ARB_CHANNEL_ID_EN
    assign m00_axi_rid    = r_rid;
`endif

endmodule

// File: tb/tb_axi_channel_arbiter.sv
// Self-checking bench for axi_channel_arbiter: directed scenarios plus random traffic against a queue-based model.
// Built with MAX_BEATS=4 so forced release is reachable; checks m00_axi_rid when ARB_CHANNEL_ID_EN is defined.
module tb_axi_channel_arbiter;

    localparam int DW   = 128;
    localparam int MAXB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] s00_axi_wdata, s01_axi_wdata, s20_axi_wdata, s21_axi_wdata;
    logic          s00_axi_wvalid, s01_axi_wvalid, s20_axi_wvalid, s21_axi_wvalid;
    logic          s00_axi_wlast, s01_axi_wlast, s20_axi_wlast, s21_axi_wlast;
    logic          s00_axi_wready, s01_axi_wready, s20_axi_wready, s21_axi_wready;
    logic [DW-1:0] m00_axi_rdata;
    logic          m00_axi_rvalid, m00_axi_rlast, m00_axi_rready;
    logic [3:0]    grant;
`ifdef ARB_CHANNEL_ID_EN
    logic [1:0]    m00_axi_rid;
`endif

    axi_channel_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .clock(clock), .reset(reset),
        .s00_axi_wdata(s00_axi_wdata), .s00_axi_wvalid(s00_axi_wvalid),
        .s00_axi_wlast(s00_axi_wlast), .s00_axi_wready(s00_axi_wready),
        .s01_axi_wdata(s01_axi_wdata), .s01_axi_wvalid(s01_axi_wvalid),
        .s01_axi_wlast(s01_axi_wlast), .s01_axi_wready(s01_axi_wready),
        .s20_axi_wdata(s20_axi_wdata), .s20_axi_wvalid(s20_axi_wvalid),
        .s20_axi_wlast(s20_axi_wlast), .s20_axi_wready(s20_axi_wready),
        .s21_axi_wdata(s21_axi_wdata), .s21_axi_wvalid(s21_axi_wvalid),
        .s21_axi_wlast(s21_axi_wlast), .s21_axi_wready(s21_axi_wready),
        .m00_axi_rdata(m00_axi_rdata), .m00_axi_rvalid(m00_axi_rvalid),
        .m00_axi_rlast(m00_axi_rlast), .m00_axi_rready(m00_axi_rready),
`ifdef ARB_CHANNEL_ID_EN
        .m00_axi_rid(m00_axi_rid),
`endif
        .grant(grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            id;
    } outBeat_t;

    beat_t    srcQ[4][$];
    outBeat_t expQ[$];
    int       mOwner = -1;
    int       mPtr = 0;
    int       mBeats = 0;
    bit       mJustReset = 1'b1;
    bit       gate[4];
    bit       rr;
    bit       rst;
    int       total = 0;
    int       bad = 0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pushPacket(input int c, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = randData();
            b.last = (i == len - 1);
            srcQ[c].push_back(b);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance the model across the edge.
    task automatic applyStimulus();
        logic [3:0]    vv;
        logic [DW-1:0] dd[4];
        logic          ll[4];
        logic [3:0]    expGrant;
        logic [3:0]    expReady;
        logic [3:0]    obsReady;
        bit            outRoom;
        bit            endPkt;
        bit            found;
        int            c;
        outBeat_t      ob;
        for (int k = 0; k < 4; k++) begin
            vv[k] = gate[k] && (srcQ[k].size() > 0);
            dd[k] = vv[k] ? srcQ[k][0].data : '0;
            ll[k] = vv[k] ? srcQ[k][0].last : 1'b0;
        end
        s00_axi_wdata = dd[0]; s00_axi_wvalid = vv[0]; s00_axi_wlast = ll[0];
        s01_axi_wdata = dd[1]; s01_axi_wvalid = vv[1]; s01_axi_wlast = ll[1];
        s20_axi_wdata = dd[2]; s20_axi_wvalid = vv[2]; s20_axi_wlast = ll[2];
        s21_axi_wdata = dd[3]; s21_axi_wvalid = vv[3]; s21_axi_wlast = ll[3];
        m00_axi_rready = rr;
        reset = rst;
        #1;
        outRoom  = (expQ.size() == 0) || rr;
        expGrant = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        expReady = (mOwner >= 0 && outRoom) ? (4'b0001 << mOwner) : 4'b0000;
        obsReady = {s21_axi_wready, s20_axi_wready, s01_axi_wready, s00_axi_wready};
        checkOutput("grant", DW'(grant), DW'(expGrant));
        checkOutput("wready", DW'(obsReady), DW'(expReady));
        checkOutput("rvalid", DW'(m00_axi_rvalid), DW'(expQ.size() > 0));
        if (expQ.size() > 0) begin
            checkOutput("rdata", m00_axi_rdata, expQ[0].data);
            checkOutput("rlast", DW'(m00_axi_rlast), DW'(expQ[0].last));
`ifdef ARB_CHANNEL_ID_EN
            checkOutput("rid", DW'(m00_axi_rid), DW'(2'(expQ[0].id)));
`endif
        end
        if (mJustReset) begin
            checkOutput("resetRdata", m00_axi_rdata, '0);
            checkOutput("resetRlast", DW'(m00_axi_rlast), '0);
`ifdef ARB_CHANNEL_ID_EN
            checkOutput("resetRid", DW'(m00_axi_rid), '0);
`endif
        end
        if (rst) begin
            mOwner = -1; mPtr = 0; mBeats = 0;
            expQ.delete();
            mJustReset = 1'b1;
        end else begin
            mJustReset = 1'b0;
            if (expQ.size() > 0 && rr) void'(expQ.pop_front());
            if (mOwner < 0) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    c = (mPtr + k) % 4;
                    if (!found && vv[c]) begin
                        found = 1'b1; mOwner = c; mBeats = 0;
                    end
                end
            end else if (vv[mOwner] && outRoom) begin
                mBeats++;
                endPkt = ll[mOwner] || (mBeats == MAXB);
                ob.data = dd[mOwner]; ob.last = endPkt; ob.id = mOwner;
                expQ.push_back(ob);
                void'(srcQ[mOwner].pop_front());
                if (endPkt) begin
                    mPtr = (mOwner + 1) % 4; mOwner = -1; mBeats = 0;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) srcQ[k].delete();
        runCycles(2);
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) gate[k] = 1'b1;
        rr = 1'b1;
        rst = 1'b1;
        reset = 1'b1;
        m00_axi_rready = 1'b1;
        {s00_axi_wvalid, s01_axi_wvalid, s20_axi_wvalid, s21_axi_wvalid} = 4'b0;
        {s00_axi_wlast, s01_axi_wlast, s20_axi_wlast, s21_axi_wlast} = 4'b0;
        s00_axi_wdata = '0; s01_axi_wdata = '0; s20_axi_wdata = '0; s21_axi_wdata = '0;
        repeat (3) @(negedge clock);
        rst = 1'b0;

        $display("[TB] single s01 packet");
        pushPacket(1, 3);
        runCycles(8);

        $display("[TB] all four channels, one-beat packets");
        doReset();
        for (int k = 0; k < 4; k++) begin
            pushPacket(k, 1);
            pushPacket(k, 1);
        end
        runCycles(20);

        $display("[TB] forced release on s20");
        doReset();
        pushPacket(2, 6);
        runCycles(14);

        $display("[TB] downstream stall mid-burst");
        doReset();
        pushPacket(3, 6);
        runCycles(3);
        rr = 1'b0;
        runCycles(5);
        rr = 1'b1;
        runCycles(10);

        $display("[TB] reset during s21 burst");
        doReset();
        pushPacket(3, 4);
        runCycles(2);
        rst = 1'b1;
        runCycles(1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) srcQ[k].delete();
        pushPacket(3, 2);
        pushPacket(0, 1);
        runCycles(10);

        $display("[TB] interleaved s00/s21 packets");
        doReset();
        pushPacket(0, 2);
        pushPacket(3, 3);
        pushPacket(0, 1);
        runCycles(16);

        $display("[TB] random traffic");
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < 4; k++) gate[k] = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 2) == 0) begin
                int c;
                c = $urandom_range(0, 3);
                if (srcQ[c].size() < 12) pushPacket(c, $urandom_range(1, 6));
            end
            applyStimulus();
        end
        rst = 1'b0;
        rr  = 1'b1;
        for (int k = 0; k < 4; k++) gate[k] = 1'b1;
        runCycles(300);
        for (int k = 0; k < 4; k++) checkOutput("drainSrc", DW'(srcQ[k].size()), '0);
        checkOutput("drainOut", DW'(expQ.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_channel_arbiter.md
AXI_CHANNEL_ARBITER -- requirements
Module: axi_channel_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: width of every sample word (16 x 8-bit samples).
REQ-002 SHALL have parameter MAX_BEATS, default 256: maximum beats per grant before forced release (legal range 2..65535).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have, for each XX in {00,01,20,21}, port sXX_axi_wdata, input, DATA_WIDTH bits: channel XX data.
REQ-006 SHALL have, for each XX, port sXX_axi_wvalid, input, 1 bit: channel XX data valid.
REQ-007 SHALL have, for each XX, port sXX_axi_wlast, input, 1 bit: last beat of a channel XX packet.
REQ-008 SHALL have, for each XX, port sXX_axi_wready, output, 1 bit: channel XX beat accepted.
REQ-009 SHALL have port m00_axi_rdata, output, DATA_WIDTH bits: merged output data.
REQ-010 SHALL have port m00_axi_rvalid, output, 1 bit: output valid.
REQ-011 SHALL have port m00_axi_rlast, output, 1 bit: output packet end.
REQ-012 SHALL have port m00_axi_rready, input, 1 bit: downstream ready.
REQ-013 SHALL have port grant, output, 4 bits: one-hot owner, bit0=00, bit1=01, bit2=20, bit3=21; zero when IDLE.

Function
REQ-014 SHALL implement two states: IDLE (no owner) and BURST (one channel owns the output).
REQ-015 In IDLE, any wvalid SHALL select an owner by round-robin, searching upward from the channel after the last owner, wrapping 21->00; after reset the search starts at 00; entry to BURST takes one cycle and no beat is accepted in the IDLE cycle.
REQ-016 In BURST, only the owner's wready MAY be high; it SHALL be high when the output register is empty or m00_axi_rready is high; all other wready SHALL be 0.
REQ-017 An accepted beat (owner wvalid && wready) SHALL appear on m00_axi_rdata/rvalid/rlast on the next cycle; latency is exactly 1 cycle, with no bubbles while both sides are ready.
REQ-018 The output register SHALL hold data, rlast and rvalid stable while rvalid=1 and m00_axi_rready=0.
REQ-019 A 16-bit beat counter SHALL clear on BURST entry and increment per accepted beat.
REQ-020 Accepting a beat with wlast=1 SHALL return the state to IDLE on the next cycle, with the counter cleared.
REQ-021 Accepting beat number MAX_BEATS with wlast=0 SHALL force m00_axi_rlast=1 on that beat, return to IDLE, and advance the round-robin pointer (forced release).
REQ-022 Owner wvalid=0 mid-burst SHALL keep the grant; no timeout.
REQ-023 Requests arriving during BURST SHALL wait; arbitration happens only in IDLE.
REQ-024 On return to IDLE with other requests pending, the next grant SHALL be the next requester in round-robin order after the previous owner.

Reset
REQ-025 While reset=1 at a clock edge: state=IDLE, grant=0, all wready=0, m00_axi_rvalid=0, m00_axi_rlast=0, m00_axi_rdata=0, counter=0, pointer=00.
REQ-026 Reset mid-burst SHALL drop any undelivered output beat; the first post-reset grant follows REQ-015.

Configuration
REQ-027 With macro ARB_CHANNEL_ID_EN defined, SHALL add output m00_axi_rid (2 bits, reset 0), registered alongside data and holding the owner index (00=0, 01=1, 20=2, 21=3) for each output beat.
REQ-028 Without ARB_CHANNEL_ID_EN, m00_axi_rid SHALL NOT exist; all other behaviour is identical.

Verification
REQ-029 After reset, s01 sends 3 beats (A,B,C; wlast on C) with rready=1 -> grant=0010 one cycle later; A,B,C output on consecutive cycles, each 1 cycle after acceptance; rlast only with C; grant=0000 afterwards.
REQ-030 All four valid with 1-beat packets, rready=1 -> grant order 00,01,20,21,00; no channel receives two grants before the others are served.
REQ-031 MAX_BEATS=4, s20 streams 6 beats, wlast on beat 6 -> rlast on beat 4, return to IDLE, re-grant to s20 if alone; beats 5,6 delivered with rlast on 6.
REQ-032 rready held 0 for 5 cycles mid-burst -> output stable, owner wready=0 after 1 buffered beat, no data lost or duplicated after release.
REQ-033 Assert reset during beat 2 of a 4-beat s21 burst -> next cycle all outputs zero; a new s00 request is granted first.
REQ-034 With ARB_CHANNEL_ID_EN, interleaved 00/21 packets -> m00_axi_rid = 0 then 3, aligned with each packet's beats.
